// File: rtl/led_pattern_gen.sv
// LED pattern generator: blink, chase, bounce and binary count patterns stepped by a prescaler.
// Optional output dimming through a free-running PWM counter when LED_PWM_DIM_EN is defined.
module led_pattern_gen #(
    parameter int WIDTH    = 16,
    parameter int DIV      = 150000000,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic                load,
    input  logic [PWM_BITS-1:0] duty,
    output logic [WIDTH-1:0]    led,
    output logic                tick
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);

    typedef enum logic [1:0] {
        MODE_BLINK  = 2'b00,
        MODE_CHASE  = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic [PW-1:0]    presc_q, presc_n;
    logic [WIDTH-1:0] pattern_q, pattern_n;
    dir_t             dir_q, dir_n;
    mode_t            mode_q, mode_n;
    logic             tick_n;
    logic             reinit;

    function automatic logic [WIDTH-1:0] init_pattern(input mode_t m);
        logic [WIDTH-1:0] p;
        p = '0;
        if (m == MODE_CHASE || m == MODE_BOUNCE)
            p = WIDTH'(1);
        return p;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q   <= RELOAD;
            pattern_q <= '0;
            dir_q     <= DIR_LEFT;
            mode_q    <= MODE_BLINK;
            tick      <= 1'b0;
        end else begin
            presc_q   <= presc_n;
            pattern_q <= pattern_n;
            dir_q     <= dir_n;
            mode_q    <= mode_n;
            tick      <= tick_n;
        end
    end

    // A mode change or load restarts the pattern regardless of en and wins over a due step.
    assign reinit = load || (mode != mode_q);

    always_comb begin
        presc_n   = presc_q;
        pattern_n = pattern_q;
        dir_n     = dir_q;
        mode_n    = mode_q;
        tick_n    = 1'b0;
        if (reinit) begin
            presc_n   = RELOAD;
            pattern_n = init_pattern(mode_t'(mode));
            dir_n     = DIR_LEFT;
            mode_n    = mode_t'(mode);
        end else if (en) begin
            if (presc_q == '0) begin
                presc_n = RELOAD;
                tick_n  = 1'b1;
                case (mode_q)
                    MODE_BLINK: pattern_n = ~pattern_q;
                    MODE_CHASE: pattern_n = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
                    MODE_BOUNCE: begin
                        // Ends reverse and move one position inward in the same step.
                        if (dir_q == DIR_LEFT) begin
                            if (pattern_q[WIDTH-1]) begin
                                dir_n     = DIR_RIGHT;
                                pattern_n = pattern_q >> 1;
                            end else begin
                                pattern_n = pattern_q << 1;
                            end
                        end else begin
                            if (pattern_q[0]) begin
                                dir_n     = DIR_LEFT;
                                pattern_n = pattern_q << 1;
                            end else begin
                                pattern_n = pattern_q >> 1;
                            end
                        end
                    end
                    default: pattern_n = pattern_q + WIDTH'(1);
                endcase
            end else begin
                presc_n = presc_q - PW'(1);
            end
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                pwm_on;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pwm_cnt <= '0;
        else
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end

    // All-ones duty must be fully on, which the plain compare cannot reach.
    assign pwm_on = (duty == '1) || (pwm_cnt < duty);
    assign led    = pattern_q & {WIDTH{pwm_on}};
`else
    logic unused_duty;
    assign unused_duty = ^duty;
    assign led         = pattern_q;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed testbench for led_pattern_gen with WIDTH=8, DIV=4, PWM_BITS=4.
module tb_led_pattern_gen;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] duty;
    logic [7:0] led;
    logic       tick;

    int checks = 0;
    int errors = 0;

    led_pattern_gen #(.WIDTH(8), .DIV(4), .PWM_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .load  (load),
        .duty  (duty),
        .led   (led),
        .tick  (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step_clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_state: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_clocks(5);
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
    endtask

    task automatic test_chase;
        logic [7:0] exp;
        mode = 2'b01;
        en   = 1'b1;
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL chase_init: led=%h tick=%b expected led=01 tick=0", led, tick);
        end
        exp = 8'h01;
        for (int s = 0; s < 8; s++) begin
            step_clocks(3);
            checks++;
            if ({led, tick} !== {exp, 1'b0}) begin
                errors++;
                $display("[TB] FAIL chase_hold%0d: led=%h tick=%b expected led=%h tick=0", s, led, tick, exp);
            end
            exp = {exp[6:0], exp[7]};
            step_clocks(1);
            checks++;
            if ({led, tick} !== {exp, 1'b1}) begin
                errors++;
                $display("[TB] FAIL chase_step%0d: led=%h tick=%b expected led=%h tick=1", s, led, tick, exp);
            end
        end
    endtask

    task automatic test_bounce;
        logic [7:0] seq [16];
        seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
        mode = 2'b10;
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL bounce_init: led=%h tick=%b expected led=01 tick=0", led, tick);
        end
        for (int s = 0; s < 16; s++) begin
            step_clocks(4);
            checks++;
            if ({led, tick} !== {seq[s], 1'b1}) begin
                errors++;
                $display("[TB] FAIL bounce_step%0d: led=%h tick=%b expected led=%h tick=1", s, led, tick, seq[s]);
            end
        end
    endtask

    task automatic test_count_freeze;
        mode = 2'b11;
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL count_init: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        step_clocks(254 * 4);
        checks++;
        if (led !== 8'hFE) begin
            errors++;
            $display("[TB] FAIL count_fe: led=%h expected FE", led);
        end
        step_clocks(4);
        checks++;
        if ({led, tick} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("[TB] FAIL count_ff: led=%h tick=%b expected led=FF tick=1", led, tick);
        end
        step_clocks(4);
        checks++;
        if ({led, tick} !== {8'h00, 1'b1}) begin
            errors++;
            $display("[TB] FAIL count_wrap: led=%h tick=%b expected led=00 tick=1", led, tick);
        end
        step_clocks(2);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_clocks(1);
            checks++;
            if ({led, tick} !== {8'h00, 1'b0}) begin
                errors++;
                $display("[TB] FAIL freeze%0d: led=%h tick=%b expected led=00 tick=0", i, led, tick);
            end
        end
        en = 1'b1;
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL resume_hold: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h01, 1'b1}) begin
            errors++;
            $display("[TB] FAIL resume_step: led=%h tick=%b expected led=01 tick=1", led, tick);
        end
    endtask

    task automatic test_load_blink;
        mode = 2'b00;
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL blink_init: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        step_clocks(4);
        checks++;
        if ({led, tick} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("[TB] FAIL blink_step: led=%h tick=%b expected led=FF tick=1", led, tick);
        end
        step_clocks(3);
        load = 1'b1;
        step_clocks(1);
        load = 1'b0;
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_priority: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        step_clocks(3);
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL load_hold: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'hFF, 1'b1}) begin
            errors++;
            $display("[TB] FAIL load_next_tick: led=%h tick=%b expected led=FF tick=1", led, tick);
        end
    endtask

    task automatic test_reset_mid;
        mode = 2'b11;
        step_clocks(1);
        step_clocks(5 * 4);
        checks++;
        if (led !== 8'h05) begin
            errors++;
            $display("[TB] FAIL pre_reset_count: led=%h expected 05", led);
        end
        step_clocks(2);
        reset = 1'b1;
        mode  = 2'b01;
        #1;
        checks++;
        if ({led, tick} !== {8'h00, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset: led=%h tick=%b expected led=00 tick=0", led, tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_reset_mode: led=%h tick=%b expected led=01 tick=0", led, tick);
        end
        step_clocks(3);
        checks++;
        if ({led, tick} !== {8'h01, 1'b0}) begin
            errors++;
            $display("[TB] FAIL post_reset_hold: led=%h tick=%b expected led=01 tick=0", led, tick);
        end
        step_clocks(1);
        checks++;
        if ({led, tick} !== {8'h02, 1'b1}) begin
            errors++;
            $display("[TB] FAIL post_reset_step: led=%h tick=%b expected led=02 tick=1", led, tick);
        end
    endtask

`ifdef LED_PWM_DIM_EN
    task automatic test_pwm;
        int on_count;
        mode = 2'b01;
        load = 1'b1;
        step_clocks(1);
        load = 1'b0;
        en   = 1'b0;
        duty = 4'd4;
        on_count = 0;
        for (int i = 0; i < 16; i++) begin
            step_clocks(1);
            if (led[0] === 1'b1) on_count++;
        end
        checks++;
        if (on_count !== 4) begin
            errors++;
            $display("[TB] FAIL pwm_duty4: on=%0d expected 4", on_count);
        end
        duty = 4'd15;
        on_count = 0;
        for (int i = 0; i < 16; i++) begin
            step_clocks(1);
            if (led[0] === 1'b1) on_count++;
        end
        checks++;
        if (on_count !== 16) begin
            errors++;
            $display("[TB] FAIL pwm_duty15: on=%0d expected 16", on_count);
        end
        en = 1'b1;
    endtask
`endif

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'b00;
        load  = 1'b0;
        duty  = 4'hF;
        test_reset();
        test_chase();
        test_bounce();
        test_count_freeze();
        test_load_blink();
        test_reset_mid();
`ifdef LED_PWM_DIM_EN
        test_pwm();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the LED vector width (>=2).
REQ-002 The block SHALL have parameter DIV, default 150000000, giving the clocks per pattern step (>=2).
REQ-003 The block SHALL have parameter PWM_BITS, default 4, giving the dimming resolution.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: run enable; 0 freezes the prescaler and the pattern.
REQ-007 The block SHALL have port mode, input, 2 bits: 00 blink, 01 chase, 10 bounce, 11 binary count.
REQ-008 The block SHALL have port load, input, 1 bit: single-cycle pulse that restarts the current mode.
REQ-009 The block SHALL have port duty, input, PWM_BITS bits: brightness.
REQ-010 The block SHALL have port led, output, WIDTH bits: the LED drive.
REQ-011 The block SHALL have port tick, output, 1 bit: one-cycle pulse on every pattern step.

Function
REQ-012 The prescaler SHALL be a down-counter of width $clog2(DIV) that reloads DIV-1 when it reaches 0; steps SHALL occur exactly every DIV enabled clocks.
REQ-013 tick SHALL be registered and high for exactly one cycle, in the same cycle the new pattern appears on led.
REQ-014 When en=0, the prescaler, pattern, direction and tick SHALL hold, with tick forced to 0.
REQ-015 Blink mode SHALL invert all pattern bits on each step; its initial value SHALL be all zeros.
REQ-016 Chase mode SHALL rotate a one-hot pattern left; MSB SHALL wrap to LSB; initial value 1.
REQ-017 Bounce mode SHALL move a one-hot pattern left from initial value 1 with direction=left.
REQ-018 In bounce mode, when the pattern is at the MSB it SHALL reverse to right and step to MSB-1; when it is at the LSB moving right it SHALL reverse to left and step to bit 1.
REQ-019 Count mode SHALL increment the pattern by 1 modulo 2^WIDTH from initial value 0; all-ones SHALL wrap to 0.
REQ-020 A mode value differing from the registered mode, or load=1, SHALL on the next edge reinitialise the pattern and direction, reload the prescaler to DIV-1, register the new mode, and suppress tick for that cycle.
REQ-021 Reinitialisation (REQ-020) SHALL take priority over a coincident step; reinitialisation SHALL occur even when en=0.
REQ-022 The first step after a reinitialisation SHALL occur DIV enabled clocks later.

Reset
REQ-023 Asserting reset SHALL immediately set the prescaler to DIV-1, the pattern to 0, direction to left, the registered mode to 00, tick to 0, the PWM counter to 0, and led to 0.
REQ-024 After release, a non-00 mode SHALL be applied via REQ-020 on the first edge; reset asserted mid-step SHALL discard all progress.

Configuration
REQ-025 With macro LED_PWM_DIM_EN defined, a free-running PWM_BITS counter SHALL gate the output as led = pattern AND (pwm_cnt < duty), with duty = all ones forcing full on and duty = 0 forcing off.
REQ-026 Without LED_PWM_DIM_EN, led SHALL equal the pattern register, duty SHALL be ignored, and no PWM counter SHALL exist.

Verification (WIDTH=8, DIV=4, macro off unless stated)
REQ-027 Chase, en=1: led 0x01 then 0x02 after 4 clocks; ...0x80 then 0x01; tick pulses every 4 clocks.
REQ-028 Bounce: the sequence SHALL be 0x01..0x80, 0x40..0x01, 0x02, with direction flips exactly at the ends.
REQ-029 Count from 0xFE: steps 0xFF then 0x00; dropping en for 10 clocks mid-count SHALL freeze led and tick, with the spacing preserved on resume.
REQ-030 Load asserted in the cycle the prescaler hits 0 in blink mode (led 0xFF): led SHALL be 0x00 with no tick, and the next tick SHALL come 4 clocks later.
REQ-031 Reset asserted mid-count (led 0x05): led SHALL be 0x00 without a clock edge; after release with mode=01, led SHALL be 0x01 after one edge.
REQ-032 LED_PWM_DIM_EN, PWM_BITS=4, duty=4, chase: led[0] SHALL be high 4 of every 16 clocks; duty=15 SHALL give continuous on.
